// File: rtl/mux_n_stream.sv
// N-channel valid/ready stream mux with fixed-select or round-robin arbitration
// feeding a single registered output stage (latency 1, full throughput).
module mux_n_stream #(
  parameter  int unsigned WIDTH    = 32,
  parameter  int unsigned CHANNELS = 4,
  localparam int unsigned SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  output logic [SEL_W-1:0]          out_chan,
  input  logic                      out_ready
);

  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] out_chan_q,  out_chan_d;
  logic [SEL_W-1:0] rr_last_q,   rr_last_d;

  logic             load_c;
  logic             grant_valid_c;
  logic [SEL_W-1:0] grant_c;
  logic             xfer_c;

  // Channel visited k steps after the last round-robin winner.
  function automatic logic [SEL_W-1:0] rr_index(input logic [SEL_W-1:0] last,
                                                input int unsigned     k);
    return SEL_W'((32'(last) + k) % CHANNELS);
  endfunction

  // Grant selection; reverse scan so the nearest channel after rr_last wins.
  always_comb begin
    grant_valid_c = 1'b0;
    grant_c       = '0;
    if (!mode) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (sel == SEL_W'(i) && in_valid[i]) begin
          grant_valid_c = 1'b1;
          grant_c       = SEL_W'(i);
        end
      end
    end else begin
      for (int unsigned k = CHANNELS; k > 0; k--) begin
        if (in_valid[rr_index(rr_last_q, k)]) begin
          grant_valid_c = 1'b1;
          grant_c       = rr_index(rr_last_q, k);
        end
      end
    end
  end

  // Handshake and next-state of the output register; no accepts during reset.
  always_comb begin
    load_c      = !out_valid_q || out_ready;
    xfer_c      = load_c && grant_valid_c && rst_n;
    in_ready    = '0;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_chan_d  = out_chan_q;
    rr_last_d   = rr_last_q;
    if (xfer_c) begin
      in_ready[grant_c] = 1'b1;
    end
    if (load_c) begin
      out_valid_d = grant_valid_c;
    end
    if (xfer_c) begin
      out_data_d = in_data[32'(grant_c)*WIDTH +: WIDTH];
      out_chan_d = grant_c;
      if (mode) begin
        rr_last_d = grant_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_chan_q  <= '0;
      rr_last_q   <= SEL_W'(CHANNELS - 1);
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_chan_q  <= out_chan_d;
      rr_last_q   <= rr_last_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_chan  = out_chan_q;

endmodule

// File: doc/mux_n_stream.md
Name: mux_n_stream

Overview:
- Parametrised successor to the 2:1 32-bit select mux: N input channels of WIDTH bits multiplexed onto one registered output stream.
- Valid/ready handshake on every port.
- Two selection modes: fixed (external select) and round-robin.
- Sits between the syndrome/sample producers and the decoder datapath, merging several producer streams into one consumer without dropping or duplicating words.

Parameters:
- WIDTH, 32, data bits per channel.
- CHANNELS, 4, number of input channels; legal range 2..16.
- SEL_W, derived localparam = ceil(log2(CHANNELS)), width of channel indices. Not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_data  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  CHANNELS  per-channel data valid.
- in_ready  output  CHANNELS  per-channel accept; combinational.
- mode  input  1  0 = fixed select, 1 = round-robin.
- sel  input  SEL_W  channel index used in fixed mode.
- out_data  output  WIDTH  registered output word.
- out_valid  output  1  registered output valid.
- out_chan  output  SEL_W  registered index of the channel out_data came from.
- out_ready  input  1  downstream accept.

Behaviour:
- Reset, evaluated at the clk edge while rst_n=0:
  - out_valid=0, out_data=0, out_chan=0.
  - Round-robin pointer rr_last = CHANNELS-1, so channel 0 has first priority.
  - rst_n=0 mid-transfer discards the held word; nothing is replayed.
- Load enable: load = !out_valid || out_ready. This gives a single register stage with latency 1: an input accepted at edge k appears on out_data after edge k.
- Grant, combinational each cycle:
  - Fixed mode: grant = sel if sel < CHANNELS and in_valid[sel]=1. Otherwise no grant.
  - Round-robin mode: grant = first i with in_valid[i]=1, searching rr_last+1, rr_last+2, ... and wrapping modulo CHANNELS. No grant if all in_valid are 0.
- in_ready[i] = load && (a grant exists) && (i == grant). At most one bit is set. in_ready never depends on in_valid of other channels except through the grant.
- Transfer: on a clk edge with in_valid[g] && in_ready[g]:
  - out_data <= in_data[g], out_chan <= g, out_valid <= 1.
  - In round-robin mode, rr_last <= g.
- Output drain: load=1 with no grant clears out_valid to 0. out_data and out_chan hold their last values.
- Stall: while out_valid=1 and out_ready=0, out_data, out_chan and out_valid hold, and all in_ready are 0.
- Back-to-back: out_valid=1, out_ready=1 and a grant present replaces the word in the same cycle, giving full throughput of 1 word/clk.
- rr_last updates only on a transfer in round-robin mode.
  - Fixed-mode transfers leave it unchanged.
  - Switching mode 0->1 resumes from the retained pointer.
- mode and sel are sampled combinationally. A change takes effect for the grant in the same cycle it is presented. A word already in the output register is unaffected.
- sel >= CHANNELS (possible when CHANNELS is not a power of 2): no grant, no transfer, the output drains normally.
- Fairness: in round-robin mode with all channels continuously valid and out_ready=1, each channel is granted exactly once per CHANNELS cycles.

Test Plan:
- Reset/hold: rst_n=0 for 2 clk with all in_valid=1 -> out_valid=0, out_data=0, out_chan=0, in_ready=0 throughout; first grant after release goes to ch0 in round-robin mode.
- Fixed mode: CHANNELS=4, mode=0, sel=2, in_data ch2=32'hA5A5_0002 valid, out_ready=1 -> in_ready=4'b0100; next cycle out_data=32'hA5A5_0002, out_chan=2, out_valid=1; ch0/1/3 are never accepted.
- Round-robin fairness: mode=1, all in_valid=1, out_ready=1 for 8 clk -> out_chan sequence 0,1,2,3,0,1,2,3 with no gaps.
- Sparse round-robin: only ch1 and ch3 valid -> out_chan alternates 1,3,1,3; dropping ch3 valid -> ch1 is granted every cycle.
- Backpressure: out_ready=0 for 3 clk with a word held -> out_data/out_chan stable, in_ready=0; out_ready=1 -> the next word loads the same cycle, with no loss or duplication, checked by a scoreboard against input order.
- Invalid select and mid-operation reset:
  - CHANNELS=3, mode=0, sel=3 -> no in_ready asserted and out_valid falls to 0 after the drain.
  - rst_n=0 while out_valid=1, out_ready=0 -> out_valid=0 the next cycle.
